// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receiver and transmitter:
//   - uart_state_t  : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - PARITY_*      : values of the PARITY parameter (none / even / odd)
//   - sample_point(): oversample count at which a state takes its bit sample
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // START samples half a bit after the falling edge, landing on the centre of
    // the start bit. Every later state counts one full bit period from there,
    // so its sample also lands on a bit centre.
    function automatic int sample_point(input uart_state_t st, input int oversample);
        return (st == ST_START) ? (oversample / 2 - 1) : (oversample - 1);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Brings the asynchronous rx pin into the clk domain and produces the bit
//   value the receiver FSM acts on, together with the strobe marking when that
//   value is meaningful.
//
//   Optional feature, selected by the macro UART_RX_MAJORITY_EN:
//     defined     - bit_val is the majority of rx_s at counts S-2, S-1 and S
//     not defined - bit_val is rx_s at count S
//   Timing and ports are identical in both builds.
//
//   Ports
//     clk        in   system clock
//     reset      in   asynchronous, active-low
//     baud_tick  in   oversample tick
//     rx         in   raw serial line (idle high)
//     cnt        in   current oversample count from the FSM
//     sample_pt  in   count S at which the current state samples
//     rx_s       out  synchronised line
//     bit_val    out  sampled bit value, valid when sample_stb is high
//     sample_stb out  one-clk pulse: tick at count S
module uart_rx_sampler #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             baud_tick,
    input  logic             rx,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] sample_pt,
    output logic             rx_s,
    output logic             bit_val,
    output logic             sample_stb
);

    logic rx_meta;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign sample_stb = baud_tick && (cnt == sample_pt);

`ifdef UART_RX_MAJORITY_EN
    // rx_s captured on the two ticks before the current one, i.e. at counts
    // S-2 and S-1 when the current tick is at S.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= 2'b11;
        end else if (baud_tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver. Recovers frames from the asynchronous rx line
//   using an external oversample tick and presents each word in a valid/ready
//   holding register with framing, parity and overrun status.
//
//   Optional feature macro: UART_RX_MAJORITY_EN (majority-of-three bit
//   sampling inside uart_rx_sampler). The default build samples once.
//
//   Parameters
//     DATA_BITS   data bits per frame, 5..9, LSB first
//     OVERSAMPLE  baud_tick pulses per bit, power of two, 8..64
//     PARITY      0 none, 1 even, 2 odd
//     STOP_BITS   1 or 2
//
//   Ports
//     clk         in   system clock
//     reset       in   asynchronous, active-low
//     baud_tick   in   one-clk pulse, OVERSAMPLE per bit period
//     rx          in   serial line, idle high, unsynchronised
//     rx_ready    in   consumer accepts the word when rx_valid & rx_ready
//     rx_valid    out  holding register contains a word
//     rx_data     out  received word, stable while rx_valid
//     frame_err   out  word had a 0 in a stop bit (qualified by rx_valid)
//     parity_err  out  parity mismatch (qualified by rx_valid)
//     overrun     out  one-clk pulse: completed word dropped, register full
//     busy        out  FSM not idle
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [CNT_W-1:0]     sample_pt;
    logic [3:0]           bit_idx, bit_idx_nxt;
    logic                 stop_idx, stop_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_flag, par_flag_nxt;
    logic                 frm_flag, frm_flag_nxt;
    logic                 armed, armed_nxt;
    logic                 done, done_nxt;

    logic rx_s;
    logic bit_val;
    logic sample_stb;

    assign sample_pt = CNT_W'(sample_point(state, OVERSAMPLE));

    uart_rx_sampler #(
        .CNT_W (CNT_W)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .cnt        (cnt),
        .sample_pt  (sample_pt),
        .rx_s       (rx_s),
        .bit_val    (bit_val),
        .sample_stb (sample_stb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
            armed    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_idx <= stop_idx_nxt;
            shreg    <= shreg_nxt;
            par_flag <= par_flag_nxt;
            frm_flag <= frm_flag_nxt;
            armed    <= armed_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        shreg_nxt    = shreg;
        par_flag_nxt = par_flag;
        frm_flag_nxt = frm_flag;
        armed_nxt    = armed;
        done_nxt     = 1'b0;

        if (baud_tick) begin
            // Count wraps at the sample point so the next state starts a
            // fresh bit period from the sample just taken.
            cnt_nxt = (cnt == sample_pt) ? '0 : cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    cnt_nxt = '0;
                    // A low line only counts as a start edge once the line
                    // has been seen high; a line stuck low after a framing
                    // error therefore never retriggers.
                    if (rx_s) begin
                        armed_nxt = 1'b1;
                    end else if (armed) begin
                        state_nxt = ST_START;
                    end
                end

                ST_START: begin
                    if (sample_stb) begin
                        if (!bit_val) begin
                            state_nxt    = ST_DATA;
                            bit_idx_nxt  = '0;
                            par_flag_nxt = 1'b0;
                            frm_flag_nxt = 1'b0;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end

                ST_DATA: begin
                    if (sample_stb) begin
                        shreg_nxt = {bit_val, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state_nxt    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            stop_idx_nxt = 1'b0;
                        end else begin
                            bit_idx_nxt = bit_idx + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (sample_stb) begin
                        par_flag_nxt = (^{shreg, bit_val}) != (PARITY == PARITY_ODD);
                        state_nxt    = ST_STOP;
                        stop_idx_nxt = 1'b0;
                    end
                end

                ST_STOP: begin
                    if (sample_stb) begin
                        if (!bit_val) begin
                            frm_flag_nxt = 1'b1;
                        end
                        if (stop_idx == LAST_STOP) begin
                            state_nxt = ST_IDLE;
                            armed_nxt = bit_val;
                            done_nxt  = 1'b1;
                        end else begin
                            stop_idx_nxt = stop_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Holding register. A completed frame is loaded one clk after the final
    // stop tick. A consumer handshake in that same clk frees the register, so
    // the new word replaces the old one without an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shreg;
                    frame_err  <= frm_flag;
                    parity_err <= par_flag;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
//   Bench for uart_rx_param. Three receivers share the clock and baud tick:
//     dut_m  8N1   main instance (table, overrun, glitch, reset cases)
//     dut_e  8E1   even parity
//     dut_o  8O2   odd parity, two stop bits
//   Expected words go into a per-instance queue when a frame is driven and are
//   popped and compared when the receiver hands the word over.
module tb_uart_rx_param;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic baud_tick = 1'b0;
    logic rx_m = 1'b1, rx_e = 1'b1, rx_o = 1'b1;
    logic rdy_m = 1'b1, rdy_e = 1'b1, rdy_o = 1'b1;

    logic       v_m, fe_m, pe_m, ov_m, busy_m;
    logic [7:0] d_m;
    logic       v_e, fe_e, pe_e, ov_e, busy_e;
    logic [7:0] d_e;
    logic       v_o, fe_o, pe_o, ov_o, busy_o;
    logic [7:0] d_o;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut_m (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_m), .rx_ready(rdy_m),
        .rx_valid(v_m), .rx_data(d_m), .frame_err(fe_m), .parity_err(pe_m),
        .overrun(ov_m), .busy(busy_m));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_e), .rx_ready(rdy_e),
        .rx_valid(v_e), .rx_data(d_e), .frame_err(fe_e), .parity_err(pe_e),
        .overrun(ov_e), .busy(busy_e));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(2)) dut_o (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_o), .rx_ready(rdy_o),
        .rx_valid(v_o), .rx_data(d_o), .frame_err(fe_o), .parity_err(pe_o),
        .overrun(ov_o), .busy(busy_o));

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    typedef struct {
        int         w;
        logic [7:0] d;
        int         par;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int ov_total = 0;

    always #5 clk = ~clk;

    initial begin : tickgen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div == TICK_DIV - 1) ? 0 : div + 1;
            baud_tick = (div == 0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    function automatic void push_exp(input int w, input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        case (w)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    task automatic pop_check(input int w, input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (w)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word inst%0d got=%02h expected=none", w, d);
        end else begin
            chk($sformatf("rx_data inst%0d", w), 32'(d), 32'(e.d));
            chk($sformatf("frame_err inst%0d", w), 32'(fe), 32'(e.fe));
            chk($sformatf("parity_err inst%0d", w), 32'(pe), 32'(e.pe));
        end
    endtask

    // Sample just before the rising edge: the handshake seen here is the one
    // that edge performs.
    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            if (v_m && rdy_m) pop_check(0, d_m, fe_m, pe_m);
            if (v_e && rdy_e) pop_check(1, d_e, fe_e, pe_e);
            if (v_o && rdy_o) pop_check(2, d_o, fe_o, pe_o);
            if (ov_m) ov_total++;
        end
    end

    task automatic set_line(input int w, input logic v);
        case (w)
            0:       rx_m = v;
            1:       rx_e = v;
            default: rx_o = v;
        endcase
    endtask

    task automatic hold(input int w, input logic v, input int clks);
        set_line(w, v);
        repeat (clks) @(negedge clk);
    endtask

    // par < 0: no parity bit; otherwise par[0] is the parity bit driven.
    // glitch_bit >= 0 inverts that data bit for one tick around its centre.
    task automatic send_frame(input int w, input logic [7:0] d, input int par,
                              input logic stop, input bit idle_after, input int glitch_bit);
        hold(w, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                hold(w, d[i], BIT_CLKS / 2 - TICK_DIV);
                hold(w, ~d[i], TICK_DIV);
                hold(w, d[i], BIT_CLKS / 2);
            end else begin
                hold(w, d[i], BIT_CLKS);
            end
        end
        if (par >= 0) hold(w, par[0], BIT_CLKS);
        hold(w, stop, BIT_CLKS);
        if (w == 2) hold(w, 1'b1, BIT_CLKS);
        if (idle_after) hold(w, 1'b1, BIT_CLKS);
    endtask

    task automatic wait_drain(input int max_clk);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < max_clk) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            errors++;
            $display("FAIL drain words_outstanding=%0d required=0",
                     q0.size() + q1.size() + q2.size());
            q0.delete(); q1.delete(); q2.delete();
        end
    endtask

    vec_t tbl[11];

    initial begin : main
        int ov0;
        bit bad;
        bit saw_busy;
        bit saw_valid;
        int last_busy;

        tbl[0]  = '{0, 8'hA5, -1, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1]  = '{0, 8'h00, -1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{0, 8'hFF, -1, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[3]  = '{0, 8'h3C, -1, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[4]  = '{0, 8'h81, -1, 1'b1, 8'h81, 1'b0, 1'b0};
        tbl[5]  = '{1, 8'h07,  0, 1'b1, 8'h07, 1'b0, 1'b1};
        tbl[6]  = '{1, 8'h07,  1, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[7]  = '{1, 8'h3C,  0, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[8]  = '{2, 8'h07,  0, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[9]  = '{2, 8'hC3,  0, 1'b1, 8'hC3, 1'b0, 1'b1};
        tbl[10] = '{2, 8'hC3,  1, 1'b1, 8'hC3, 1'b0, 1'b0};

        // Reset state
        repeat (5) @(negedge clk);
        chk("reset rx_valid", 32'(v_m), 32'd0);
        chk("reset rx_data", 32'(d_m), 32'd0);
        chk("reset frame_err", 32'(fe_m), 32'd0);
        chk("reset parity_err", 32'(pe_m), 32'd0);
        chk("reset overrun", 32'(ov_m), 32'd0);
        chk("reset busy", 32'(busy_m), 32'd0);
        reset = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        chk("post_reset busy", 32'(busy_m), 32'd0);

        // Table of frames across all three instances
        for (int i = 0; i < 11; i++) begin
            push_exp(tbl[i].w, tbl[i].exp_d, tbl[i].exp_fe, tbl[i].exp_pe);
            send_frame(tbl[i].w, tbl[i].d, tbl[i].par, tbl[i].stop, 1'b1, -1);
        end
        wait_drain(4 * BIT_CLKS);

        // Framing error with the line left low: no new frame until it rises
        push_exp(0, 8'h3C, 1'b1, 1'b0);
        send_frame(0, 8'h3C, -1, 1'b0, 1'b0, -1);
        bad = 1'b0;
        for (int i = 0; i < 3 * BIT_CLKS; i++) begin
            @(negedge clk);
            if (busy_m) bad = 1'b1;
        end
        chk("held_low busy_seen", 32'(bad), 32'd0);
        wait_drain(2 * BIT_CLKS);
        hold(0, 1'b1, BIT_CLKS);
        push_exp(0, 8'hC6, 1'b0, 1'b0);
        send_frame(0, 8'hC6, -1, 1'b1, 1'b1, -1);
        wait_drain(4 * BIT_CLKS);

        // Short low glitch on an idle line: START entered, abandoned at half bit
        saw_busy = 1'b0; saw_valid = 1'b0; last_busy = 0;
        set_line(0, 1'b0);
        for (int i = 0; i < 2 * BIT_CLKS; i++) begin
            if (i == 4 * TICK_DIV) set_line(0, 1'b1);
            @(negedge clk);
            if (busy_m) begin saw_busy = 1'b1; last_busy = i; end
            if (v_m) saw_valid = 1'b1;
        end
        chk("glitch start_seen", 32'(saw_busy), 32'd1);
        chk("glitch busy_within_bit", 32'(last_busy < BIT_CLKS), 32'd1);
        chk("glitch rx_valid", 32'(saw_valid), 32'd0);

        // Overrun: register full when the second word completes
        rdy_m = 1'b0;
        ov0 = ov_total;
        send_frame(0, 8'h11, -1, 1'b1, 1'b1, -1);
        send_frame(0, 8'h22, -1, 1'b1, 1'b1, -1);
        repeat (8) @(negedge clk);
        chk("overrun pulses", 32'(ov_total - ov0), 32'd1);
        chk("overrun rx_valid", 32'(v_m), 32'd1);
        chk("overrun kept_word", 32'(d_m), 32'h11);
        push_exp(0, 8'h11, 1'b0, 1'b0);
        rdy_m = 1'b1;
        wait_drain(BIT_CLKS);
        repeat (2) @(negedge clk);
        chk("rx_valid after accept", 32'(v_m), 32'd0);

        // Consumer ready in the very clk the second word completes
        rdy_m = 1'b0;
        ov0 = ov_total;
        push_exp(0, 8'h11, 1'b0, 1'b0);
        push_exp(0, 8'h22, 1'b0, 1'b0);
        send_frame(0, 8'h11, -1, 1'b1, 1'b1, -1);
        fork
            send_frame(0, 8'h22, -1, 1'b1, 1'b1, -1);
            begin
                int n;
                n = 0;
                while (!busy_m && n < 3 * BIT_CLKS) begin @(negedge clk); n++; end
                n = 0;
                while (busy_m && n < 12 * BIT_CLKS) begin @(negedge clk); n++; end
                if (busy_m) begin
                    checks++;
                    errors++;
                    $display("FAIL same_clk_ready busy=1 required=0 (frame end not seen)");
                end
                rdy_m = 1'b1;
            end
        join
        wait_drain(BIT_CLKS);
        chk("same_clk_ready overrun", 32'(ov_total - ov0), 32'd0);

        // Reset in the middle of data bit 3 with a word already held
        rdy_m = 1'b0;
        ov0 = ov_total;
        send_frame(0, 8'h77, -1, 1'b1, 1'b1, -1);
        chk("pre_reset rx_valid", 32'(v_m), 32'd1);
        hold(0, 1'b0, BIT_CLKS);
        hold(0, 1'b0, BIT_CLKS);
        hold(0, 1'b1, BIT_CLKS);
        hold(0, 1'b0, BIT_CLKS);
        hold(0, 1'b1, BIT_CLKS / 2);
        chk("mid_frame busy", 32'(busy_m), 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_reset rx_valid", 32'(v_m), 32'd0);
        chk("mid_reset rx_data", 32'(d_m), 32'd0);
        chk("mid_reset busy", 32'(busy_m), 32'd0);
        chk("mid_reset overrun", 32'(ov_m), 32'd0);
        set_line(0, 1'b1);
        rdy_m = 1'b1;
        reset = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("after_reset rx_valid", 32'(v_m), 32'd0);
        push_exp(0, 8'h5A, 1'b0, 1'b0);
        send_frame(0, 8'h5A, -1, 1'b1, 1'b1, -1);
        wait_drain(4 * BIT_CLKS);
        chk("reset_case overrun", 32'(ov_total - ov0), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        // One-tick glitch at the centre of data bit 1 is outvoted
        push_exp(0, 8'h5A, 1'b0, 1'b0);
        send_frame(0, 8'h5A, -1, 1'b1, 1'b1, 1);
        wait_drain(4 * BIT_CLKS);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
